store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
// - 4-entry FIFO store buffer, upstream of the data-memory interface in the MEM stage.
// - Retires stores to the single memory port in the background.
// - Loads get port priority; a load to a word still held in the buffer stalls until drained.
// - Checks sh/sw alignment before enqueue; misaligned stores never reach memory.
// PARAMETERS
// - DEPTH  4   entries, power of two, >=2
// - AW     10  byte-address width (matches data memory)
// PORTS
// - clk           in   1   clock, rising edge
// - reset_n       in   1   async active-low reset
// - req_valid     in   1   MEM-stage memory op present
// - req_ready     out  1   op accepted this cycle (comb)
// - req_is_store  in   1   1=store, 0=load
// - req_addr      in   AW  byte address
// - req_funct3    in   3   RV32 load/store funct3
// - req_wdata     in   32  store data, unshifted
// - drain_req     in   1   fence: stop accepting until empty
// - misaligned    out  1   pulse: rejected misaligned store (comb, with req_ready=1)
// - sb_empty      out  1   no valid entries
// - mem_read      out  1   downstream read strobe (comb)
// - mem_write     out  1   downstream write strobe (comb)
// - mem_addr      out  AW  downstream byte address
// - mem_funct3    out  3   downstream funct3
// - mem_wdata     out  32  downstream write data, unshifted
// - fwd_valid     out  1   load served from buffer (STORE_FORWARD_EN only, else 0)
// - fwd_data      out  32  forwarded, funct3-extended load result
// BEHAVIOUR
// - Reset: all entries invalid, rd/wr ptr=0, count=0; comb outputs follow (sb_empty=1, mem_* =0).
// - Entry: {addr, funct3, wdata, bmask[3:0]}; bmask = 0001/0011/1111 << addr[1:0] for b/h/w.
// - Misaligned: funct3[1:0]=01 with addr[0]=1, or 10 with addr[1:0]!=0.
//   - Store: misaligned=1, req_ready=1, not enqueued.
//   - Load: passed through unchanged; downstream owns the exception.
// - hit: a load whose word addr[AW-1:2] equals any valid entry and whose bmask overlaps it.
// - Port arbitration, per cycle, in priority order:
//   1. Load, no hit, !drain_req: mem_read=1, mem_*=req fields, req_ready=1. No drain this cycle.
//   2. Otherwise, if count>0: head entry drives mem_write=1, mem_*=head fields; rd_ptr++.
// - Store enqueue: req_ready=1 when count<DEPTH && !drain_req; written at wr_ptr, wr_ptr++.
// - Simultaneous enqueue and drain: count unchanged; a full buffer accepts a store in its drain cycle.
// - Load with hit: req_ready=0, drain continues until hit clears.
// - drain_req: req_ready=0 for all ops until sb_empty=1; deassert is the requester's job.
// - Pointers: log2(DEPTH) bits, natural wrap. count: log2(DEPTH)+1 bits, never exceeds DEPTH.
// - Reset mid-operation: pending stores are discarded and never written to memory.
// - req_valid=0: req_ready=0 (don't-care); no state change except drain.
// CONFIGURATION
// - STORE_FORWARD_EN defined:
//   - Load hit with youngest matching entry's bmask covering the load bmask:
//     fwd_valid=1, req_ready=1, mem_read=0, and the port drains the head in the same cycle.
//   - fwd_data = (wdata<<8*off)>>8*load_off, then extended per funct3 (lb/lh sign; lbu/lhu zero).
//   - Partial cover still stalls.
// - STORE_FORWARD_EN undefined: fwd_valid=0, fwd_data=0; every hit stalls.
// TESTING
// - Reset, then 4 sw to 0x000,0x004,0x008,0x00C with no loads: 1 accepted/cycle; 4 writes follow in order.
// - 5 back-to-back sw with continuous load traffic to 0x100: 5th store accepted via full-buffer drain.
//   - Loads stall only in that cycle.
// - sw 0x010=0xDEADBEEF, then lbu 0x011:
//   - No macro: stall until mem_write to 0x010, then mem_read issued.
//   - Macro: fwd_data=0x000000BE in the same cycle.
// - sb 0x022=0x80, then lb 0x022 with macro: fwd_data=0xFFFFFF80.
//   - lh 0x022 after only that sb: stall (partial cover).
// - sh 0x031, and sw 0x042: misaligned=1, count unchanged, no mem_write ever.
// - 3 stores queued, drain_req=1: req_ready=0 for 3 cycles; then sb_empty=1.
//   - reset_n low mid-drain: next cycle mem_write=0, sb_empty=1.

Source files
------------

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - FIFO store buffer in front of the single data-memory port
// Define STORE_FORWARD_EN to serve fully covered load hits from the youngest matching entry.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_is_store,
  input  logic [AW-1:0] req_addr,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_wdata,
  input  logic          drain_req,
  output logic          misaligned,
  output logic          sb_empty,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [2:0]    mem_funct3,
  output logic [31:0]   mem_wdata,
  output logic          fwd_valid,
  output logic [31:0]   fwd_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    addr_q  [DEPTH];
  logic [2:0]       f3_q    [DEPTH];
  logic [31:0]      wdata_q [DEPTH];
  logic [3:0]       bmask_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [3:0]       req_bmask;
  logic [DEPTH-1:0] match_age;
  logic             req_misal, is_load, is_store, blocked, hit;
  logic             load_go, fwd_go, drain, enq;

  function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   byte_mask = 4'b0001 << off;
      2'b01:   byte_mask = 4'b0011 << off;
      default: byte_mask = 4'b1111 << off;
    endcase
  endfunction

  assign req_bmask = byte_mask(req_funct3, req_addr[1:0]);
  assign req_misal = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign is_load   = req_valid && !req_is_store;
  assign is_store  = req_valid && req_is_store;
  assign sb_empty  = (count_q == '0);
  assign blocked   = drain_req && !sb_empty;

  // match_age[k] refers to the k-th oldest valid entry
  always_comb begin
    logic [PW-1:0] idx;
    match_age = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q && addr_q[idx][AW-1:2] == req_addr[AW-1:2] &&
          (bmask_q[idx] & req_bmask) != 4'b0000)
        match_age[k] = 1'b1;
    end
  end
  assign hit = is_load && (match_age != '0);

`ifdef STORE_FORWARD_EN
  logic [31:0] src_data, shifted, fwd_ext;
  logic [3:0]  src_mask;
  logic [1:0]  src_off;

  always_comb begin
    logic [PW-1:0] idx;
    src_data = '0;
    src_mask = '0;
    src_off  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (match_age[k]) begin
        src_data = wdata_q[idx];
        src_mask = bmask_q[idx];
        src_off  = addr_q[idx][1:0];
      end
    end
    shifted = (src_data << {src_off, 3'b000}) >> {req_addr[1:0], 3'b000};
    case (req_funct3)
      3'b000:  fwd_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  fwd_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  fwd_ext = {24'b0, shifted[7:0]};
      3'b101:  fwd_ext = {16'b0, shifted[15:0]};
      default: fwd_ext = shifted;
    endcase
  end

  assign fwd_go    = hit && !req_misal && !blocked && ((src_mask & req_bmask) == req_bmask);
  assign fwd_valid = fwd_go;
  assign fwd_data  = fwd_go ? fwd_ext : 32'h0;
`else
  assign fwd_go    = 1'b0;
  assign fwd_valid = 1'b0;
  assign fwd_data  = 32'h0;
`endif

  assign load_go    = is_load && !hit && !blocked;
  assign drain      = !load_go && !sb_empty;
  assign misaligned = is_store && req_misal && !blocked;
  // a full buffer still takes a store because the head retires in the same cycle
  assign enq        = is_store && !req_misal && !blocked && (count_q < CW'(DEPTH) || drain);
  assign req_ready  = load_go || fwd_go || misaligned || enq;

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_funct3 = '0;
    mem_wdata  = '0;
    if (load_go) begin
      mem_read   = 1'b1;
      mem_addr   = req_addr;
      mem_funct3 = req_funct3;
      mem_wdata  = req_wdata;
    end else if (drain) begin
      mem_write  = 1'b1;
      mem_addr   = addr_q[rd_ptr_q];
      mem_funct3 = f3_q[rd_ptr_q];
      mem_wdata  = wdata_q[rd_ptr_q];
    end
  end

  assign rd_ptr_d = rd_ptr_q + PW'(drain);
  assign wr_ptr_d = wr_ptr_q + PW'(enq);
  assign count_d  = count_q + CW'(enq) - CW'(drain);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr_q]  <= req_addr;
      f3_q[wr_ptr_q]    <= req_funct3;
      wdata_q[wr_ptr_q] <= req_wdata;
      bmask_q[wr_ptr_q] <= req_bmask;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - store_buffer bench: directed scenarios plus random traffic against a byte-level queue model
module tb_store_buffer;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0, req_is_store = 1'b0, drain_req = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [2:0]    req_funct3 = '0;
  logic [31:0]   req_wdata = '0;
  logic          req_ready, misaligned, sb_empty, mem_read, mem_write, fwd_valid;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_funct3;
  logic [31:0]   mem_wdata, fwd_data;

`ifdef STORE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_addr(req_addr), .req_funct3(req_funct3),
    .req_wdata(req_wdata), .drain_req(drain_req), .misaligned(misaligned),
    .sb_empty(sb_empty), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_funct3(mem_funct3), .mem_wdata(mem_wdata),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data)
  );

  typedef struct {
    int          addr;
    int          f3;
    logic [31:0] wdata;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input int f3);
    return ((f3 & 3) == 0) ? 1 : ((f3 & 3) == 1) ? 2 : 4;
  endfunction

  function automatic bit is_misal(input int a, input int f3);
    return ((f3 & 3) == 1 && (a % 2) != 0) || ((f3 & 3) == 2 && (a % 4) != 0);
  endfunction

  function automatic bit holds(input ent_t e, input int b);
    return b >= e.addr && b < e.addr + nbytes(e.f3);
  endfunction

  // One cycle: drive at negedge, compare against the queue model, advance the model.
  task automatic step(input bit v, input bit st, input int a, input int f3,
                      input logic [31:0] wd, input bit dr);
    bit hit, cov, blocked, rd, fw, dg, enq, mis;
    int y, n;
    ent_t e;
    logic [31:0] fd, ex_addr, ex_f3, ex_wd;
    @(negedge clk);
    req_valid = v; req_is_store = st; req_addr = AW'(a); req_funct3 = 3'(f3);
    req_wdata = wd; drain_req = dr;
    #1;
    hit = 0; y = -1; n = nbytes(f3);
    if (v && !st)
      for (int i = 0; i < q.size(); i++)
        for (int b = a; b < a + n; b++)
          if (b / 4 == a / 4 && holds(q[i], b)) begin
            hit = 1; y = i;
          end
    cov = 0; fd = '0;
    if (hit) begin
      e = q[y]; cov = 1;
      for (int k = 0; k < n; k++) begin
        if (!holds(e, a + k)) cov = 0;
        else fd[8*k +: 8] = e.wdata[8*(a + k - e.addr) +: 8];
      end
      if (f3 == 0) fd = {{24{fd[7]}}, fd[7:0]};
      if (f3 == 1) fd = {{16{fd[15]}}, fd[15:0]};
    end
    blocked = dr && q.size() != 0;
    rd  = v && !st && !hit && !blocked;
    fw  = FWD && v && !st && hit && cov && !blocked && !is_misal(a, f3);
    dg  = !rd && q.size() != 0;
    mis = v && st && !blocked && is_misal(a, f3);
    enq = v && st && !blocked && !mis && (q.size() < 4 || dg);
    ex_addr = rd ? a : dg ? q[0].addr : 0;
    ex_f3   = rd ? f3 : dg ? q[0].f3 : 0;
    ex_wd   = rd ? wd : dg ? q[0].wdata : 0;
    chk("req_ready",  req_ready,  rd || fw || mis || enq);
    chk("misaligned", misaligned, mis);
    chk("sb_empty",   sb_empty,   q.size() == 0);
    chk("mem_read",   mem_read,   rd);
    chk("mem_write",  mem_write,  dg);
    chk("mem_addr",   mem_addr,   ex_addr);
    chk("mem_funct3", mem_funct3, ex_f3);
    chk("mem_wdata",  mem_wdata,  ex_wd);
    chk("fwd_valid",  fwd_valid,  fw);
    chk("fwd_data",   fwd_data,   fw ? fd : 32'h0);
    if (dg) q.delete(0);
    if (enq) begin
      e.addr = a; e.f3 = f3; e.wdata = wd;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    int a, f3, sel;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_empty", sb_empty, 1'b1);
    chk("rst_wr", mem_write, 1'b0);
    chk("rst_rd", mem_read, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      step(1, 1, 4*i, 2, 32'h1000 + i, 0);
      chk("t1_acc", req_ready, 1'b1);
      if (i > 0) chk("t1_waddr", mem_addr, 32'(4*(i-1)));
    end
    step(0, 0, 0, 0, 32'h0, 0);
    chk("t1_last", mem_addr, 32'h00C);
    idle(1);

    for (int i = 0; i < 5; i++) begin
      step(1, 0, 'h100, 2, 32'h0, 0);
      chk("t2_ld", mem_read, 1'b1);
      step(1, 1, 'h200 + 4*i, 2, 32'hA0 + i, 0);
      chk("t2_st", req_ready, 1'b1);
    end
    idle(2);

    step(1, 1, 'h010, 2, 32'hDEADBEEF, 0);
    step(1, 0, 'h011, 4, 32'h0, 0);
    if (FWD) chk("t3_fwd", fwd_data, 32'h000000BE);
    else begin
      chk("t3_stall", req_ready, 1'b0);
      chk("t3_wr", mem_addr, 32'h010);
    end
    step(1, 0, 'h011, 4, 32'h0, 0);
    chk("t3_rd", mem_read, 1'b1);

    step(1, 1, 'h022, 0, 32'h00000080, 0);
    step(1, 0, 'h022, 1, 32'h0, 0);
    chk("t4_partial", req_ready, 1'b0);
    step(1, 1, 'h022, 0, 32'h00000080, 0);
    step(1, 0, 'h022, 0, 32'h0, 0);
    if (FWD) chk("t4_lb", fwd_data, 32'hFFFFFF80);
    else chk("t4_stall", req_ready, 1'b0);
    idle(2);

    step(1, 1, 'h031, 1, 32'h1234, 0);
    chk("t5_sh", misaligned, 1'b1);
    step(1, 1, 'h042, 2, 32'h5678, 0);
    chk("t5_sw", misaligned, 1'b1);
    step(0, 0, 0, 0, 32'h0, 0);
    chk("t5_nowr", mem_write, 1'b0);
    chk("t5_empty", sb_empty, 1'b1);

    step(1, 1, 'h050, 2, 32'h11, 0);
    step(1, 1, 'h054, 2, 32'h22, 0);
    step(1, 1, 'h058, 2, 32'h33, 1);
    chk("t6_block", req_ready, 1'b0);
    step(0, 0, 0, 0, 32'h0, 1);
    chk("t6_empty", sb_empty, 1'b1);

    step(1, 1, 'h060, 2, 32'h44, 0);
    step(1, 1, 'h064, 2, 32'h55, 0);
    @(negedge clk);
    reset_n = 1'b0; req_valid = 1'b0; drain_req = 1'b1;
    #1;
    chk("t7_nowr", mem_write, 1'b0);
    chk("t7_empty", sb_empty, 1'b1);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1; drain_req = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      a = $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) a = a + 'h100;
      if ($urandom_range(0, 1) == 1) begin
        f3 = $urandom_range(0, 2);
        step($urandom_range(0, 4) != 0, 1, a, f3, $urandom, $urandom_range(0, 9) == 0);
      end else begin
        sel = $urandom_range(0, 4);
        f3 = (sel < 3) ? sel : sel + 1;
        a = a & ~(nbytes(f3) - 1);
        step($urandom_range(0, 4) != 0, 0, a, f3, $urandom, $urandom_range(0, 9) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
